// File: rtl/fmcw_adc_framer.sv
// fmcw_adc_framer: captures one sweep-gated frame of interleaved multi-channel
// ADC samples per sawtooth, decimates it (pick or boxcar mean), tags each word
// and streams it toward the ping-pong buffer.
// Ports:
//   ADC_clk, rst_n          clock, async active-low reset
//   SAWTOOTH_DSYNC          async sweep start (synchronised, rising edge)
//   ADC_DSYNC, ADC_DATA     channel-0 marker and sample stream
//   avg_en                  0 = pick, 1 = boxcar average (latched at frame start)
//   out_valid/out_data/out_last  tagged word stream {tag[3:0], sample}
//   buf_sel, buf_rst        ping-pong select, buffer reset during echo delay
//   frame_cnt, frame_done   completed-frame count and pulse
//   overrun, sync_err       aborted-frame and DSYNC-misalignment pulses
module fmcw_adc_framer #(
  parameter int CH_NUM    = 6,
  parameter int DATA_W    = 12,
  parameter int POINTS    = 256,
  parameter int DIV_LOG2  = 4,
  parameter int DELAY_CYC = 900
) (
  input  logic              ADC_clk,
  input  logic              rst_n,
  input  logic              SAWTOOTH_DSYNC,
  input  logic              ADC_DSYNC,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              avg_en,
  output logic              out_valid,
  output logic [DATA_W+3:0] out_data,
  output logic              out_last,
  output logic              buf_sel,
  output logic              buf_rst,
  output logic [7:0]        frame_cnt,
  output logic              frame_done,
  output logic              overrun,
  output logic              sync_err
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int PT_W  = $clog2(POINTS);
  localparam int DEC_W = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam int DLY_W = $clog2(DELAY_CYC + 1);
  localparam int ACC_W = DATA_W + DIV_LOG2;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(POINTS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'((1 << DIV_LOG2) - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYC - 1);

  typedef enum logic [2:0] {IDLE, DELAY, ALIGN, CAPTURE, FINISH} state_t;

  state_t            state;
  logic [2:0]        sync_q;
  logic              sweep_edge;
  logic              avg_mode;
  logic [DLY_W-1:0]  dcnt;
  logic [CH_W-1:0]   ch;
  logic [DEC_W-1:0]  dec;
  logic [PT_W-1:0]   pt;
  logic [ACC_W-1:0]  acc [CH_NUM];

  logic [CH_W-1:0]   take_ch;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] sample;
  logic [3:0]        tag;
  logic              emit;
  logic              is_last;
  logic              accept;
  logic              misalign;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value
  always_ff @(posedge ADC_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], SAWTOOTH_DSYNC};
  end

  assign sweep_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    // A DSYNC cycle is always treated as channel 0, whether it arrives on time,
    // early (realignment), or as the first sample after ALIGN.
    take_ch  = (state == ALIGN || ADC_DSYNC) ? '0 : ch;
    sum      = ((dec == '0) ? '0 : acc[take_ch]) + ACC_W'(ADC_DATA);
    emit     = avg_mode ? (dec == DEC_LAST) : (dec == '0);
    sample   = avg_mode ? DATA_W'(sum >> DIV_LOG2) : ADC_DATA;
    is_last  = emit && (pt == PT_LAST) && (take_ch == CH_LAST);
    accept   = (state == ALIGN && ADC_DSYNC) ||
               (state == CAPTURE && (ADC_DSYNC || ch != '0));
    misalign = (state == CAPTURE) && (ADC_DSYNC != (ch == '0));
    tag      = 4'(take_ch) + 4'd1;
    if (pt == '0) begin
      if (take_ch == CH_W'(0))      tag = 4'hE;
      else if (take_ch == CH_W'(1)) tag = frame_cnt[7:4];
      else if (take_ch == CH_W'(2)) tag = frame_cnt[3:0];
    end else if (pt == PT_LAST && take_ch == CH_LAST) begin
      tag = 4'hF;
    end
  end

  always_ff @(posedge ADC_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      avg_mode   <= 1'b0;
      dcnt       <= '0;
      ch         <= '0;
      dec        <= '0;
      pt         <= '0;
      acc        <= '{default: '0};
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      buf_sel    <= 1'b0;
      buf_rst    <= 1'b0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_edge) begin
            buf_sel  <= ~buf_sel;
            avg_mode <= avg_en;
            dcnt     <= '0;
            buf_rst  <= 1'b1;
            state    <= DELAY;
          end
        end
        DELAY, ALIGN, CAPTURE: begin
          if (sweep_edge) begin
            overrun <= 1'b1;
            buf_sel <= ~buf_sel;
            dcnt    <= '0;
            buf_rst <= 1'b1;
            state   <= DELAY;
          end else if (state == DELAY) begin
            if (dcnt == DLY_LAST) begin
              buf_rst <= 1'b0;
              ch      <= '0;
              dec     <= '0;
              pt      <= '0;
              state   <= ALIGN;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end else if (misalign && !ADC_DSYNC) begin
            // Missing DSYNC: drop the sample and wait for the marker; dec/pt
            // are kept so the same raw point is captured again.
            sync_err <= 1'b1;
            state    <= ALIGN;
          end else if (accept) begin
            sync_err     <= misalign;
            acc[take_ch] <= sum;
            if (emit) begin
              out_valid <= 1'b1;
              out_data  <= {tag, sample};
              out_last  <= is_last;
            end
            if (is_last) begin
              state <= FINISH;
            end else begin
              state <= CAPTURE;
              if (take_ch == CH_LAST) begin
                ch  <= '0;
                dec <= (dec == DEC_LAST) ? '0 : dec + 1'b1;
                if (dec == DEC_LAST) pt <= pt + 1'b1;
              end else begin
                ch <= take_ch + 1'b1;
              end
            end
          end
        end
        FINISH: begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          // An edge landing here starts the next frame straight away.
          if (sweep_edge) begin
            buf_sel  <= ~buf_sel;
            avg_mode <= avg_en;
            dcnt     <= '0;
            buf_rst  <= 1'b1;
            state    <= DELAY;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmcw_adc_framer.sv
// Self-checking bench for fmcw_adc_framer (CH_NUM=6, POINTS=4, DIV=4, DELAY=10).
module tb_fmcw_adc_framer;

  localparam int C = 6;
  localparam int P = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SAWTOOTH_DSYNC;
  logic        ADC_DSYNC;
  logic [11:0] ADC_DATA;
  logic        avg_en;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        buf_sel;
  logic        buf_rst;
  logic [7:0]  frame_cnt;
  logic        frame_done;
  logic        overrun;
  logic        sync_err;

  fmcw_adc_framer #(
    .CH_NUM(C), .DATA_W(12), .POINTS(P), .DIV_LOG2(2), .DELAY_CYC(10)
  ) dut (
    .ADC_clk(clk), .rst_n(rst_n), .SAWTOOTH_DSYNC(SAWTOOTH_DSYNC),
    .ADC_DSYNC(ADC_DSYNC), .ADC_DATA(ADC_DATA), .avg_en(avg_en),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .buf_sel(buf_sel), .buf_rst(buf_rst), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .overrun(overrun), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, n_last, n_done, n_ovr, n_serr, n_brst, n_brst_rise, last_cyc, done_cyc;
  logic prev_brst = 1'b0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  logic [11:0] rnd [C][P*D];
  int   exp_fc = 0;
  logic exp_bs = 1'b0;

  function automatic logic [11:0] data_for(int kind, int ch, int raw);
    case (kind)
      0:       return 12'(ch * 256 + raw);
      1:       return rnd[ch][raw % (P*D)];
      default: return 12'hFFF;
    endcase
  endfunction

  // Reference: word (pt,ch) is the raw sample at the point's first raw index,
  // or the integer mean of the point's D raw samples.
  function automatic void build_exp(bit avg, int kind, int fc);
    exp_q.delete();
    for (int p = 0; p < P; p++) begin
      for (int c = 0; c < C; c++) begin
        int s;
        logic [3:0] tg;
        logic lst;
        if (!avg) s = data_for(kind, c, p*D);
        else begin
          s = 0;
          for (int d = 0; d < D; d++) s += data_for(kind, c, p*D + d);
          s = s / D;
        end
        if (p == 0) tg = (c == 0) ? 4'hE : (c == 1) ? 4'(fc / 16) : (c == 2) ? 4'(fc % 16) : 4'(c + 1);
        else if (p == P-1 && c == C-1) tg = 4'hF;
        else tg = 4'(c + 1);
        lst = (p == P-1 && c == C-1);
        exp_q.push_back({lst, tg, 12'(s)});
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) got_q.push_back({out_last, out_data});
    if (out_last) begin n_last++; last_cyc = cyc; end
    if (frame_done) begin n_done++; done_cyc = cyc; end
    if (overrun) begin n_ovr++; got_q.delete(); end
    if (sync_err) n_serr++;
    if (buf_rst) n_brst++;
    if (buf_rst && !prev_brst) n_brst_rise++;
    prev_brst = buf_rst;
  endtask

  // Drives one sweep and an ADC stream that starts with DSYNC once buf_rst drops.
  task automatic drive_frame(input bit avg, input int kind, input int hold,
                             input int glitch_raw, input int abort_raw, input int stop_raw);
    int phase = 0, gch = 0, graw = 0, abort_c = 0;
    bit aborted = 0, glitched = 0, restarted = 0;
    got_q.delete();
    n_last = 0; n_done = 0; n_ovr = 0; n_serr = 0; n_brst = 0; n_brst_rise = 0;
    last_cyc = -1; done_cyc = -1;
    avg_en = avg;
    for (int c = 0; c < hold + 400; c++) begin
      SAWTOOTH_DSYNC = (c < hold) || (aborted && c < abort_c + 3);
      if (phase == 2) begin
        if (abort_raw >= 0 && !aborted && graw == abort_raw && gch == 0) begin
          aborted = 1; abort_c = c; SAWTOOTH_DSYNC = 1'b1;
        end
        if (glitch_raw >= 0 && !glitched && graw == glitch_raw && gch == 3) begin
          glitched = 1; gch = 0;
        end
        ADC_DSYNC = (gch == 0);
        ADC_DATA  = data_for(kind, gch, graw);
        gch++;
        if (gch == C) begin gch = 0; graw++; end
      end else begin
        ADC_DSYNC = 1'b0;
        ADC_DATA  = 12'($urandom);
      end
      tick();
      if (phase == 0 && buf_rst) phase = 1;
      else if (phase == 1 && !buf_rst) begin phase = 2; gch = 0; graw = 0; end
      else if (phase == 2 && aborted && !restarted && n_ovr > 0) begin phase = 1; restarted = 1; end
      else if (phase == 2 && n_done > 0) phase = 3;
      if (phase == 3 && c >= hold + 10) break;
      if (stop_raw >= 0 && phase == 2 && graw >= stop_raw) break;
    end
    SAWTOOTH_DSYNC = 1'b0;
    ADC_DSYNC = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SAWTOOTH_DSYNC = 1'b0; ADC_DSYNC = 1'b0; ADC_DATA = '0; avg_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_data, out_last, buf_sel, buf_rst, frame_cnt, frame_done, overrun, sync_err} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_data, out_last, buf_sel, buf_rst, frame_cnt, frame_done, overrun, sync_err});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pick();
    drive_frame(0, 0, 3, -1, -1, -1);
    exp_bs = ~exp_bs;
    build_exp(0, 0, exp_fc);
    exp_fc++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL pick_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      logic [16:0] g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) $display("FAIL pick_word[%0d] got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
    n_checks++; if (n_brst !== 10) $display("FAIL pick_buf_rst_len got=%0d exp=10", n_brst); else n_pass++;
    n_checks++; if (buf_sel !== exp_bs) $display("FAIL pick_buf_sel got=%b exp=%b", buf_sel, exp_bs); else n_pass++;
    n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL pick_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); else n_pass++;
    n_checks++; if (n_last !== 1 || n_done !== 1) $display("FAIL pick_last_done got=%0d/%0d exp=1/1", n_last, n_done); else n_pass++;
    n_checks++; if (done_cyc !== last_cyc + 1) $display("FAIL pick_done_timing got=%0d exp=%0d", done_cyc, last_cyc + 1); else n_pass++;
  endtask

  task automatic test_average();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < P*D; r++) rnd[c][r] = 12'($urandom);
    rnd[0][0] = 12'd4; rnd[0][1] = 12'd8; rnd[0][2] = 12'd12; rnd[0][3] = 12'd16;
    for (int kind = 1; kind <= 2; kind++) begin
      drive_frame(1, kind, 3, -1, -1, -1);
      exp_bs = ~exp_bs;
      build_exp(1, kind, exp_fc);
      exp_fc++;
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL avg%0d_count got=%0d exp=%0d", kind, got_q.size(), exp_q.size()); else n_pass++;
      foreach (exp_q[i]) begin
        logic [16:0] g = (i < got_q.size()) ? got_q[i] : 'x;
        n_checks++; if (g !== exp_q[i]) $display("FAIL avg%0d_word[%0d] got=%h exp=%h", kind, i, g, exp_q[i]); else n_pass++;
      end
      if (kind == 1 && got_q.size() > 0) begin
        n_checks++; if (got_q[0][11:0] !== 12'd10) $display("FAIL avg_ch0_mean got=%0d exp=10", got_q[0][11:0]); else n_pass++;
      end
      n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL avg%0d_frame_cnt got=%0d exp=%0d", kind, frame_cnt, exp_fc); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    drive_frame(0, 0, 3, -1, 8, -1);
    exp_bs = ~exp_bs; exp_bs = ~exp_bs;
    build_exp(0, 0, exp_fc);
    exp_fc++;
    n_checks++; if (n_ovr !== 1) $display("FAIL abort_overrun got=%0d exp=1", n_ovr); else n_pass++;
    n_checks++; if (n_last !== 1 || n_done !== 1) $display("FAIL abort_last_done got=%0d/%0d exp=1/1", n_last, n_done); else n_pass++;
    n_checks++; if (buf_sel !== exp_bs) $display("FAIL abort_buf_sel got=%b exp=%b", buf_sel, exp_bs); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL abort_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      logic [16:0] g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) $display("FAIL abort_word[%0d] got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
    n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL abort_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); else n_pass++;
  endtask

  task automatic test_sync_err();
    drive_frame(0, 0, 3, 5, -1, -1);
    exp_bs = ~exp_bs;
    build_exp(0, 0, exp_fc);
    exp_fc++;
    n_checks++; if (n_serr !== 1) $display("FAIL sync_err_pulses got=%0d exp=1", n_serr); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL sync_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      logic [16:0] g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) $display("FAIL sync_word[%0d] got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
    n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL sync_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); else n_pass++;
  endtask

  task automatic test_level_hold();
    drive_frame(0, 0, 5000, -1, -1, -1);
    exp_bs = ~exp_bs;
    exp_fc++;
    n_checks++; if (n_done !== 1 || n_brst_rise !== 1) $display("FAIL hold_frames got=%0d/%0d exp=1/1", n_done, n_brst_rise); else n_pass++;
    n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL hold_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); else n_pass++;
    n_checks++; if (buf_sel !== exp_bs) $display("FAIL hold_buf_sel got=%b exp=%b", buf_sel, exp_bs); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    drive_frame(0, 0, 3, -1, -1, 6);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_last, buf_sel, buf_rst, frame_cnt, frame_done, overrun, sync_err} !== '0)
      $display("FAIL midreset_outputs got=%h exp=0", {out_valid, out_data, out_last, buf_sel, buf_rst, frame_cnt, frame_done, overrun, sync_err});
    else n_pass++;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_fc = 0; exp_bs = 1'b0;
    drive_frame(0, 0, 3, -1, -1, -1);
    exp_bs = ~exp_bs;
    build_exp(0, 0, exp_fc);
    exp_fc++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL clean_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      logic [16:0] g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) $display("FAIL clean_word[%0d] got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
    n_checks++; if (buf_sel !== exp_bs) $display("FAIL clean_buf_sel got=%b exp=%b", buf_sel, exp_bs); else n_pass++;
    n_checks++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL clean_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pick();
    test_average();
    test_back_to_back();
    test_sync_err();
    test_level_hold();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmcw_adc_framer.md
Name: fmcw_adc_framer

Overview:
- Parametrised successor to the current fixed 6-channel AD9283 capture path.
- Captures one sweep-gated frame of interleaved multi-channel ADC samples per ADF4158 sawtooth.
- Decimates by pick or boxcar average, tags each word with channel/header/end codes, and drives the ping-pong buffer toward cyusb_interface.
- Adds edge-detected sweep start, DSYNC realignment, overrun and sync-error reporting.

Parameters:
CH_NUM, 6, channels interleaved per ADC_DSYNC period; legal range 3..13.
DATA_W, 12, ADC sample width.
POINTS, 256, output points per frame, one point = CH_NUM words; legal range >=2.
DIV_LOG2, 4, decimation factor DIV = 2^DIV_LOG2 raw points per output point.
DELAY_CYC, 900, ADC_clk cycles from sweep edge to capture (echo delay, 25 us at 36 MHz).
OUT_W, DATA_W+4, output word width (derived, not overridable).

Ports:
ADC_clk  in  1  sole clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
SAWTOOTH_DSYNC  in  1  asynchronous sweep-start from ADF4158.
ADC_DSYNC  in  1  high during the channel-0 sample of each interleave period.
ADC_DATA  in  DATA_W  ADC sample, valid every cycle.
avg_en  in  1  0 = pick decimation, 1 = boxcar average; sampled only in IDLE.
out_valid  out  1  out_data valid this cycle.
out_data  out  OUT_W  {tag[3:0], sample}.
out_last  out  1  with the final word of a frame.
buf_sel  out  1  ping-pong buffer address, toggles per frame start.
buf_rst  out  1  buffer reset, high throughout DELAY.
frame_cnt  out  8  completed-frame counter.
frame_done  out  1  one-cycle pulse after out_last.
overrun  out  1  one-cycle pulse on an aborted frame.
sync_err  out  1  one-cycle pulse on a DSYNC misalignment.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0, sync flops 0.
- SAWTOOTH_DSYNC passes through a 2-flop synchroniser. sweep_edge = rising edge of the synchronised signal, a 3-cycle latency from the pin. Level-high without an edge does not start a frame.
- States:
  - IDLE: on sweep_edge, toggle buf_sel, latch avg_en, go to DELAY.
  - DELAY: buf_rst=1. Count DELAY_CYC cycles, then buf_rst=0 and go to ALIGN.
  - ALIGN: wait for ADC_DSYNC=1. That cycle's sample is ch0 of raw point 0; go to CAPTURE.
  - CAPTURE: ch counter 0..CH_NUM-1 advances every cycle; raw counter dec 0..DIV-1 increments when ch wraps; pt counter 0..POINTS-1 increments when dec wraps.
- Pick mode:
  - emit the sample when dec==0;
  - sample field = ADC_DATA.
- Average mode:
  - Keep per-channel accumulators of width DATA_W+DIV_LOG2.
  - dec==0 loads the sample; other dec values add it.
  - At dec==DIV-1, emit (acc+sample)>>DIV_LOG2, which is an exact truncating mean.
- Tag field:
  - pt==0: ch0=0xE, ch1=frame_cnt[7:4], ch2=frame_cnt[3:0], other channels ch+1.
  - pt==POINTS-1, ch==CH_NUM-1: 0xF.
  - otherwise: ch+1.
- Latency: out_data/out_valid registered, one cycle after the contributing sample.
- Frame end:
  - The word with pt==POINTS-1, ch==CH_NUM-1 at the emit dec has out_last=1.
  - Next cycle: frame_done=1, frame_cnt+1 (wraps 255->0), state IDLE.
- DSYNC check:
  - In CAPTURE, ADC_DSYNC=1 with ch!=0, or ADC_DSYNC=0 with ch==0, pulses sync_err.
  - ch is then forced to align: ch=0 on that DSYNC cycle, or held in a re-ALIGN wait when DSYNC is missing.
  - No word is emitted for the partial point. dec and pt are unchanged, so the interrupted point restarts.
- sweep_edge in DELAY/ALIGN/CAPTURE:
  - overrun pulse, no out_last, no frame_done, frame_cnt unchanged;
  - buf_sel toggles and DELAY restarts from 0.
- sweep_edge coincident with frame_done cycle: the frame completes normally, then the new frame starts (edge not lost).
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.

Test Plan:
Use CH_NUM=6, DATA_W=12, POINTS=4, DIV_LOG2=2, DELAY_CYC=10.
1. Reset, then one sweep edge, pick mode, ADC_DATA=ch*0x100+raw index -> buf_sel=1, buf_rst high for 10 cycles, 24 words out; first word tag 0xE, second 0x0, third 0x0; last word tag 0xF with out_last; frame_done next cycle; frame_cnt=1.
2. Average mode, ch0 raw values 4,8,12,16 per point -> ch0 word sample=10; constant 0xFFF input -> 0xFFF with no overflow.
3. Second sweep edge injected during CAPTURE at pt=2 -> overrun pulse, no out_last, buf_sel toggles back, new frame completes with frame_cnt unchanged at the abort.
4. ADC_DSYNC pulsed at ch=3 mid-capture -> sync_err pulse, partial point dropped, each channel still emitted exactly POINTS times per frame.
5. SAWTOOTH_DSYNC held high 5000 cycles -> exactly one frame captured.
6. rst_n asserted mid-CAPTURE -> all outputs 0 on the same cycle; the next edge produces a clean frame with header frame_cnt=0.
